// File: rtl/adc_cfg_pkg.sv
// Shared types and reset-time table contents
// for the ADC configuration-word sequencer.
package adc_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_OFFER,
    ST_GAP
  } state_e;

  localparam int DEF_W = 24;

  function automatic logic [DEF_W-1:0] tbl_default(input int i);
    logic [DEF_W-1:0] w;
    case (i)
      1:       w = 24'h26_AA80;
      2:       w = 24'h27_5540;
      3:       w = 24'h45_0001;
      4:       w = 24'h45_0002;
      5:       w = 24'h25_0012;
      6:       w = 24'h25_0026;
      7:       w = 24'h25_0040;
      9:       w = 24'h25_0000;
      10:      w = 24'h45_0000;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/adc_cfg_table.sv
// Config-word register file: reset defaults,
// synchronous write, registered read-first port.
module adc_cfg_table
  import adc_cfg_pkg::*;
#(
  parameter int WORD_W = 24,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = {1'b0, waddr_i} < (IDX_W+1)'(DEPTH);
  assign rd_ok = {1'b0, raddr_i} < (IDX_W+1)'(DEPTH);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WORD_W'(tbl_default(i));
      end
      rdata_q <= '0;
    end else begin
      if (we_i && wr_ok) begin
        mem_q[waddr_i] <= wdata_i;
      end
      // Out-of-range indices read as an all-zero word
      if (re_i) begin
        rdata_q <= rd_ok ? mem_q[raddr_i] : '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_cfg_sequencer.sv
// ADC serial-config sequencer: auto/manual/power-down
// word issue onto a valid/ready stream.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int WORD_W     = 24,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int NUM_CH     = 8,
  parameter int AUTO_FIRST = 1,
  parameter int AUTO_LAST  = 3,
  parameter int PWDN_IDX   = 8,
  parameter logic [WORD_W-1:0] PWDN_WORD =
    WORD_W'(24'h0F_0200),
  parameter int GAP_CYC    = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              tbl_we_i,
  input  logic [IDX_W-1:0]  tbl_waddr_i,
  input  logic [WORD_W-1:0] tbl_wdata_i,
  input  logic              start_auto_i,
  input  logic              abort_i,
  input  logic              man_req_i,
  input  logic [IDX_W-1:0]  man_idx_i,
  input  logic [NUM_CH-1:0] pwdown_ch_i,
  output logic              cfg_valid_o,
  output logic [WORD_W-1:0] cfg_word_o,
  input  logic              cfg_ready_i,
  output logic              busy_o,
  output logic              end_auto_o,
  output logic              req_err_o
);

  localparam int GAP_W =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] FIRST_C =
    IDX_W'(AUTO_FIRST);
  localparam logic [IDX_W-1:0] LAST_C =
    IDX_W'(AUTO_LAST);
  localparam logic [IDX_W-1:0] PWDN_C =
    IDX_W'(PWDN_IDX);

  if (AUTO_LAST < AUTO_FIRST) begin : g_bad_range
    $error("AUTO_LAST must not be below AUTO_FIRST");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              auto_q, auto_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              end_q, end_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] mask_q, last_q, cap_q;
  logic              sel_pw_q;
  logic              pend;
  logic              acc;
  logic              adv;
  logic [WORD_W-1:0] tbl_rdata;

  adc_cfg_table #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (clk),
    .rstb    (rstb),
    .we_i    (tbl_we_i),
    .waddr_i (tbl_waddr_i),
    .wdata_i (tbl_wdata_i),
    .re_i    (state_q == ST_RD),
    .raddr_i (idx_q),
    .rdata_o (tbl_rdata)
  );

  assign pend        = mask_q != last_q;
  assign cfg_valid_o = (state_q == ST_OFFER) && !abort_i;
  assign acc         = cfg_valid_o && cfg_ready_i;
  assign busy_o      = state_q != ST_IDLE;
  assign end_auto_o  = end_q;
  assign req_err_o   = err_q;

  always_comb begin
    cfg_word_o = '0;
    if (state_q == ST_OFFER) begin
      cfg_word_o = sel_pw_q
        ? (PWDN_WORD | WORD_W'(cap_q))
        : tbl_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      auto_q   <= 1'b0;
      gap_q    <= '0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      mask_q   <= '0;
      last_q   <= '0;
      cap_q    <= '0;
      sel_pw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      auto_q  <= auto_d;
      gap_q   <= gap_d;
      end_q   <= end_d;
      err_q   <= err_d;
      mask_q  <= pwdown_ch_i;
      // Freeze the mask so the offered word stays stable
      if (state_q == ST_RD) begin
        cap_q    <= mask_q;
        sel_pw_q <= idx_q == PWDN_C;
      end
      if (acc && sel_pw_q) begin
        last_q <= cap_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    auto_d  = auto_q;
    gap_d   = gap_q;
    end_d   = 1'b0;
    adv     = 1'b0;
    err_d   = (start_auto_i || man_req_i)
              && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start_auto_i) begin
          auto_d  = 1'b1;
          idx_d   = FIRST_C;
          state_d = ST_RD;
        end else if (pend) begin
          auto_d  = 1'b0;
          idx_d   = PWDN_C;
          state_d = ST_RD;
        end else if (man_req_i) begin
          auto_d  = 1'b0;
          idx_d   = man_idx_i;
          state_d = ST_RD;
        end
      end
      ST_RD: state_d = ST_OFFER;
      ST_OFFER: begin
        if (acc) begin
          if (GAP_CYC == 0) begin
            adv = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          adv = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      if (auto_q && idx_q != LAST_C) begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_RD;
      end else begin
        state_d = ST_IDLE;
        end_d   = auto_q;
      end
    end
    if (abort_i) begin
      state_d = ST_IDLE;
      end_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed/randomised bench for adc_cfg_sequencer
// against a table-and-timing reference model.
`timescale 1ns/1ps
module tb_adc_cfg_sequencer;

  localparam int GAP = 4;
  localparam logic [23:0] PW = 24'h0F_0200;

  logic        clk = 1'b0;
  logic        rstb;
  logic        tbl_we;
  logic [3:0]  tbl_waddr;
  logic [23:0] tbl_wdata;
  logic        start_auto;
  logic        abort;
  logic        man_req;
  logic [3:0]  man_idx;
  logic [7:0]  pwdown_ch;
  logic        cfg_valid;
  logic [23:0] cfg_word;
  logic        cfg_ready;
  logic        busy;
  logic        end_auto;
  logic        req_err;

  adc_cfg_sequencer dut (
    .clk          (clk),
    .rstb         (rstb),
    .tbl_we_i     (tbl_we),
    .tbl_waddr_i  (tbl_waddr),
    .tbl_wdata_i  (tbl_wdata),
    .start_auto_i (start_auto),
    .abort_i      (abort),
    .man_req_i    (man_req),
    .man_idx_i    (man_idx),
    .pwdown_ch_i  (pwdown_ch),
    .cfg_valid_o  (cfg_valid),
    .cfg_word_o   (cfg_word),
    .cfg_ready_i  (cfg_ready),
    .busy_o       (busy),
    .end_auto_o   (end_auto),
    .req_err_o    (req_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] mdl_tbl [16];
  logic [7:0]  mdl_mask;
  logic [23:0] exp_w[$];
  int          exp_c[$];
  int          exp_end[$];
  int          exp_err[$];
  logic [23:0] acc_w[$];
  int          acc_c[$];
  int          end_c[$];
  int          err_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstb) begin
      if (cfg_valid && cfg_ready) begin
        acc_w.push_back(cfg_word);
        acc_c.push_back(cyc);
      end
      if (end_auto) end_c.push_back(cyc);
      if (req_err) err_c.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_tbl[i] = '0;
    mdl_tbl[1]  = 24'h26_AA80;
    mdl_tbl[2]  = 24'h27_5540;
    mdl_tbl[3]  = 24'h45_0001;
    mdl_tbl[4]  = 24'h45_0002;
    mdl_tbl[5]  = 24'h25_0012;
    mdl_tbl[6]  = 24'h25_0026;
    mdl_tbl[7]  = 24'h25_0040;
    mdl_tbl[9]  = 24'h25_0000;
    mdl_tbl[10] = 24'h45_0000;
    mdl_mask = '0;
  endtask

  function automatic logic [23:0] word_at(input int i);
    if (i == 8) return PW | {16'h0, mdl_mask};
    return mdl_tbl[i];
  endfunction

  task automatic clear_mon();
    acc_w.delete(); acc_c.delete();
    end_c.delete(); err_c.delete();
    exp_w.delete(); exp_c.delete();
    exp_end.delete(); exp_err.delete();
  endtask

  // Auto run: words 1..3, each offered GAP+2 cycles
  // after the previous one; end_auto GAP+1 after last.
  task automatic plan_auto(input int c0, output int te);
    int t;
    t = c0 + 2;
    te = 0;
    for (int i = 1; i <= 3; i++) begin
      exp_w.push_back(word_at(i));
      exp_c.push_back(t);
      te = t + GAP + 1;
      t = t + GAP + 2;
    end
    exp_end.push_back(te);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_nwords"}, acc_w.size(), exp_w.size());
    for (int i = 0; i < acc_w.size() && i < exp_w.size(); i++) begin
      check({tag, "_word"}, acc_w[i], exp_w[i]);
      check({tag, "_cyc"}, acc_c[i], exp_c[i]);
    end
    check({tag, "_nend"}, end_c.size(), exp_end.size());
    for (int i = 0; i < end_c.size() && i < exp_end.size(); i++)
      check({tag, "_endcyc"}, end_c[i], exp_end[i]);
    check({tag, "_nerr"}, err_c.size(), exp_err.size());
    for (int i = 0; i < err_c.size() && i < exp_err.size(); i++)
      check({tag, "_errcyc"}, err_c[i], exp_err[i]);
  endtask

  task automatic start_pulse();
    start_auto = 1'b1;
    tick();
    start_auto = 1'b0;
  endtask

  task automatic man_pulse(input logic [3:0] idx);
    man_idx = idx;
    man_req = 1'b1;
    tick();
    man_req = 1'b0;
  endtask

  task automatic tbl_write(input logic [3:0] a,
                           input logic [23:0] d);
    tbl_we = 1'b1; tbl_waddr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
    mdl_tbl[a] = d;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_valid"}, cfg_valid, 0);
    check({tag, "_word"}, cfg_word, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_end"}, end_auto, 0);
    check({tag, "_err"}, req_err, 0);
  endtask

  initial begin
    int c0, c1, te, hold, r;
    logic [7:0]  m;
    logic [23:0] d, old3;
    rstb = 1'b0; tbl_we = 1'b0; tbl_waddr = '0;
    tbl_wdata = '0; start_auto = 1'b0; abort = 1'b0;
    man_req = 1'b0; man_idx = '0; pwdown_ch = '0;
    cfg_ready = 1'b0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("reset");
    rstb = 1'b1;
    tick(); tick();

    // Auto sequence with free-flowing ready
    clear_mon();
    cfg_ready = 1'b1;
    c0 = cyc;
    start_pulse();
    check("lat_rd_valid", cfg_valid, 0);
    check("lat_rd_busy", busy, 1);
    tick();
    check("lat_offer_valid", cfg_valid, 1);
    check("lat_offer_word", cfg_word, 24'h26_AA80);
    plan_auto(c0, te);
    go_to(te + 6);
    cmp_stream("auto");
    check("auto_idle", busy, 0);

    // Backpressure on the second word
    clear_mon();
    c0 = cyc;
    start_pulse();
    go_to(c0 + 3);
    cfg_ready = 1'b0;
    go_to(c0 + 8);
    hold = $urandom_range(8, 12);
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", cfg_valid, 1);
      check("bp_word", cfg_word, mdl_tbl[2]);
      tick();
    end
    cfg_ready = 1'b1;
    exp_w.push_back(mdl_tbl[1]); exp_c.push_back(c0 + 2);
    exp_w.push_back(mdl_tbl[2]); exp_c.push_back(c0 + 8 + hold);
    exp_w.push_back(mdl_tbl[3]); exp_c.push_back(c0 + 14 + hold);
    exp_end.push_back(c0 + 19 + hold);
    go_to(c0 + 26 + hold);
    cmp_stream("bp");

    // Power-down mask changes in IDLE
    clear_mon();
    c0 = cyc;
    pwdown_ch = 8'h5A; mdl_mask = 8'h5A;
    exp_w.push_back(24'h0F_025A); exp_c.push_back(c0 + 3);
    go_to(c0 + 10);
    pwdown_ch = 8'h5A;
    go_to(c0 + 25);
    c1 = cyc;
    do m = 8'($urandom_range(1, 255)); while (m == mdl_mask);
    pwdown_ch = m; mdl_mask = m;
    exp_w.push_back(word_at(8)); exp_c.push_back(c1 + 3);
    go_to(c1 + 10);
    cmp_stream("pwdn_idle");

    // Mask change while auto run is busy
    clear_mon();
    c0 = cyc;
    start_pulse();
    go_to(c0 + 4);
    plan_auto(c0, te);
    do m = 8'($urandom_range(1, 255)); while (m == mdl_mask);
    pwdown_ch = m; mdl_mask = m;
    exp_w.push_back(word_at(8)); exp_c.push_back(te + 2);
    go_to(te + 12);
    cmp_stream("pwdn_busy");

    // Manual request, then requests while busy
    clear_mon();
    c0 = cyc;
    man_pulse(4'd9);
    exp_w.push_back(24'h25_0000); exp_c.push_back(c0 + 2);
    go_to(c0 + 3);
    man_idx = 4'd5; man_req = 1'b1;
    tick();
    man_req = 1'b0; start_auto = 1'b1;
    tick();
    start_auto = 1'b0;
    exp_err.push_back(c0 + 4);
    exp_err.push_back(c0 + 5);
    go_to(c0 + 20);
    cmp_stream("man_busy");
    for (int k = 0; k < 3; k++) begin
      clear_mon();
      r = (k == 2) ? 8 : $urandom_range(0, 15);
      c0 = cyc;
      man_pulse(4'(r));
      exp_w.push_back(word_at(r)); exp_c.push_back(c0 + 2);
      go_to(c0 + 10);
      cmp_stream("man_rand");
    end

    // Table writes before and during an auto run
    clear_mon();
    tbl_write(4'd2, 24'h12_3456);
    tbl_write(4'd1, 24'($urandom));
    tick();
    c0 = cyc;
    start_pulse();
    plan_auto(c0, te);
    go_to(c0 + 13);
    old3 = mdl_tbl[3];
    d = 24'($urandom);
    tbl_write(4'd3, d);
    check("rdfirst_word", cfg_word, old3);
    go_to(te + 6);
    cmp_stream("tblwr");
    clear_mon();
    c0 = cyc;
    man_pulse(4'd3);
    exp_w.push_back(d); exp_c.push_back(c0 + 2);
    go_to(c0 + 10);
    cmp_stream("tblwr_new");

    // Abort in the middle of an offer
    clear_mon();
    cfg_ready = 1'b0;
    c0 = cyc;
    start_pulse();
    go_to(c0 + 3);
    check("abort_pre_valid", cfg_valid, 1);
    abort = 1'b1;
    #1;
    check("abort_imm_valid", cfg_valid, 0);
    tick();
    abort = 1'b0;
    check("abort_nxt_valid", cfg_valid, 0);
    check("abort_nxt_busy", busy, 0);
    cfg_ready = 1'b1;
    go_to(c0 + 30);
    cmp_stream("abort");

    // Asynchronous reset during GAP
    clear_mon();
    c0 = cyc;
    start_pulse();
    go_to(c0 + 4);
    check("rst_gap_busy", busy, 1);
    #2;
    rstb = 1'b0;
    pwdown_ch = '0;
    #1;
    check_idle_outs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    mdl_reset();
    tick();
    clear_mon();
    c0 = cyc;
    start_pulse();
    plan_auto(c0, te);
    go_to(te + 6);
    cmp_stream("post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
